// File: rtl/urcpu_alu_pkg.sv
// Shared types and constants for the ALU sequencer slice.
// Optional feature macro: ALU_FLAG_CHAIN_EN (carry chaining across ops).
package urcpu_alu_pkg;

    localparam int unsigned WORD_W  = 20;
    localparam int unsigned INSTR_W = 5;
    localparam int unsigned FLAG_W  = 5;

    // Flag bit positions in resp_flags / flags_q
    localparam int unsigned FLAG_C = 4;
    localparam int unsigned FLAG_V = 3;
    localparam int unsigned FLAG_U = 2;
    localparam int unsigned FLAG_S = 1;
    localparam int unsigned FLAG_Z = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } seq_state_e;

    // Operation payload latched from the winning requester
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [WORD_W-1:0]  arg0;
        logic [WORD_W-1:0]  arg1;
    } alu_op_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; on a tie the port not granted last wins.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic last_grant;

    // One-hot grant: single requester wins outright, tie goes opposite last_grant
    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = last_grant ? 2'b01 : 2'b10;
        end
    end

    // Remember which port was served on each acceptance
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (advance && (grant != 2'b00)) begin
            last_grant <= grant[1];
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// Sequences the shared ALU between two requesters with a valid/ready response.
// Optional feature macro: ALU_FLAG_CHAIN_EN (stored carry used as carry-in).
module alu_sequencer
    import urcpu_alu_pkg::*;
#(
    parameter int unsigned ALU_LATENCY = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req0_valid,
    input  logic               req1_valid,
    output logic               req0_ready,
    output logic               req1_ready,
    input  logic [INSTR_W-1:0] req0_instr,
    input  logic [INSTR_W-1:0] req1_instr,
    input  logic [WORD_W-1:0]  req0_arg0,
    input  logic [WORD_W-1:0]  req0_arg1,
    input  logic [WORD_W-1:0]  req1_arg0,
    input  logic [WORD_W-1:0]  req1_arg1,
    input  logic               req0_chain,
    input  logic               req1_chain,
    output logic               resp0_valid,
    output logic               resp1_valid,
    input  logic               resp0_ready,
    input  logic               resp1_ready,
    output logic [WORD_W-1:0]  resp_res0,
    output logic [WORD_W-1:0]  resp_res1,
    output logic [FLAG_W-1:0]  resp_flags,
    output logic [FLAG_W-1:0]  flags_q,
    output logic               alu_enable,
    output logic [INSTR_W-1:0] alu_instruction,
    output logic [WORD_W-1:0]  alu_arg0,
    output logic [WORD_W-1:0]  alu_arg1,
    output logic               alu_carry_in,
    input  logic [WORD_W-1:0]  alu_res0,
    input  logic [WORD_W-1:0]  alu_res1,
    input  logic               alu_carry_out,
    input  logic               alu_overflow_out,
    input  logic               alu_underflow_out,
    input  logic               alu_sign_out,
    input  logic               alu_zero_out
);

    localparam int unsigned CNT_W = 3;

    seq_state_e         state_q;
    seq_state_e         state_d;
    logic [1:0]         grant;
    logic               accept_c;
    logic               capture_c;
    logic               resp_done_c;
    logic               gnt_id_q;
    logic [CNT_W-1:0]   cnt_q;
    alu_op_t            sel_op_c;
    logic [FLAG_W-1:0]  alu_flags_c;

    rr_arbiter2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     ({req1_valid, req0_valid}),
        .advance (accept_c),
        .grant   (grant)
    );

    // Request ready is the grant qualified by being idle
    assign req0_ready = accept_c & grant[0];
    assign req1_ready = accept_c & grant[1];

    // Operand mux toward the winning port
    always_comb begin
        sel_op_c = grant[1] ? '{instr: req1_instr, arg0: req1_arg0, arg1: req1_arg1}
                            : '{instr: req0_instr, arg0: req0_arg0, arg1: req0_arg1};
    end

    // Pack ALU status lines into flag-register order
    always_comb begin
        alu_flags_c         = '0;
        alu_flags_c[FLAG_C] = alu_carry_out;
        alu_flags_c[FLAG_V] = alu_overflow_out;
        alu_flags_c[FLAG_U] = alu_underflow_out;
        alu_flags_c[FLAG_S] = alu_sign_out;
        alu_flags_c[FLAG_Z] = alu_zero_out;
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and control strobes
    always_comb begin
        state_d     = state_q;
        accept_c    = 1'b0;
        capture_c   = 1'b0;
        resp_done_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant != 2'b00) begin
                    accept_c = 1'b1;
                    state_d  = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (cnt_q == CNT_W'(ALU_LATENCY - 1)) begin
                    capture_c = 1'b1;
                    state_d   = ST_RESP;
                end
            end
            ST_RESP: begin
                if (gnt_id_q ? resp1_ready : resp0_ready) begin
                    resp_done_c = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Operand latch, latency count, result capture and response valids
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gnt_id_q        <= 1'b0;
            cnt_q           <= '0;
            alu_enable      <= 1'b0;
            alu_instruction <= '0;
            alu_arg0        <= '0;
            alu_arg1        <= '0;
            resp0_valid     <= 1'b0;
            resp1_valid     <= 1'b0;
            resp_res0       <= '0;
            resp_res1       <= '0;
            resp_flags      <= '0;
            flags_q         <= '0;
        end else begin
            if (accept_c || capture_c) begin
                cnt_q <= '0;
            end else if (state_q == ST_BUSY) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (accept_c) begin
                gnt_id_q        <= grant[1];
                alu_enable      <= 1'b1;
                alu_instruction <= sel_op_c.instr;
                alu_arg0        <= sel_op_c.arg0;
                alu_arg1        <= sel_op_c.arg1;
            end
            if (capture_c) begin
                alu_enable  <= 1'b0;
                resp_res0   <= alu_res0;
                resp_res1   <= alu_res1;
                resp_flags  <= alu_flags_c;
                flags_q     <= alu_flags_c;
                resp0_valid <= ~gnt_id_q;
                resp1_valid <= gnt_id_q;
            end
            if (resp_done_c) begin
                resp0_valid <= 1'b0;
                resp1_valid <= 1'b0;
            end
        end
    end

`ifdef ALU_FLAG_CHAIN_EN
    // Carry-in fixed for the whole op: stored carry when the winner asks to chain
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_carry_in <= 1'b0;
        end else if (accept_c) begin
            alu_carry_in <= (grant[1] ? req1_chain : req0_chain) & flags_q[FLAG_C];
        end
    end
`else
    // No chaining: carry-in is constant and chain requests are dropped
    logic unused_chain;
    assign unused_chain = req0_chain ^ req1_chain;
    assign alu_carry_in = 1'b0;
`endif

endmodule
